// File: rtl/cla8_seq_adder.sv
// Multi-cycle W-bit adder that steps one 8-bit carry-lookahead slice across the operand, byte by byte.
// Optional subtract mode is enabled by defining CLA8_SEQ_ADDER_SUB_EN.

module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       gg;
    logic       pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is formed from the group generate/propagate of bits [i:0] and ci.
    always_comb begin
        gg   = 1'b0;
        pp   = 1'b1;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < 8; i++) begin
            gg       = g[i] | (p[i] & gg);
            pp       = p[i] & pp;
            c[i + 1] = gg | (pp & ci);
        end
    end

    assign s  = p ^ c[7:0];
    assign co = c[8];
endmodule

module cla8_seq_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef CLA8_SEQ_ADDER_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
);
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state;
    logic [NBYTES-1:0][7:0]   opa;
    logic [NBYTES-1:0][7:0]   opb;
    logic [NBYTES-1:0][7:0]   sum_q;
    logic [CW-1:0]            cnt;
    logic                     carry;
    logic [7:0]               cla_s;
    logic                     cla_co;

    cla8 u_cla8 (
        .a  (opa[cnt]),
        .b  (opb[cnt]),
        .ci (carry),
        .s  (cla_s),
        .co (cla_co)
    );

    assign sum = sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum_q     <= '0;
            cout      <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            opa       <= '0;
            opb       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa      <= a;
`ifdef CLA8_SEQ_ADDER_SUB_EN
                        opb      <= sub ? ~b : b;
                        carry    <= sub | cin;
`else
                        opb      <= b;
                        carry    <= cin;
`endif
                        cnt      <= '0;
                        sum_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[cnt] <= cla_s;
                    carry      <= cla_co;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        cout      <= cla_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla8_seq_adder.sv
// Bench for cla8_seq_adder: directed and random transactions against an arithmetic reference.
// Subtract cases are built only when CLA8_SEQ_ADDER_SUB_EN is defined.

module tb_cla8_seq_adder;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cla8_seq_adder #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA8_SEQ_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic over W+1 bits.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    // Presents one request, waits for acceptance, checks latency/result, stalls, then drains.
    task automatic txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input logic ts, input int stall, output int acc_cyc);
        logic [W:0] exp;
        int n;
        exp = ref_add(ta, tb_v, tc, ts);
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < NB + 10) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(NB));
        chk({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
        chk({tag, "_cout"}, 64'(cout), 64'(exp[W]));
        if (stall > 0) begin
            logic [W-1:0] held_s;
            logic         held_c;
            int           bad;
            held_s = sum; held_c = cout; bad = 0;
            out_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (!out_valid || sum !== held_s || cout !== held_c) bad++;
            end
            chk({tag, "_stall_hold"}, 64'(bad), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, {62'(0), in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        int t0, t1, t2, n, bad;
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));

        // Inputs without in_valid must not start anything.
        a = 32'hDEADBEEF; b = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_hs", {62'(0), in_ready, out_valid}, 64'b10);

        txn("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, t0);
        txn("cin_only", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 5, t0);

        // Back-to-back with in_valid and out_ready both held high.
        out_ready = 1'b1;
        begin
            int acc[3];
            for (int k = 0; k < 3; k++) begin
                logic [W:0] exp;
                ra = $urandom; rb = $urandom;
                a = ra; b = rb; cin = 1'(k); in_valid = 1'b1;
                exp = ref_add(ra, rb, 1'(k), 1'b0);
                n = 0;
                while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
                @(posedge clk); #1;
                acc[k] = cyc;
                a = $urandom; b = $urandom;
                n = 0;
                while (!out_valid && n < NB + 10) begin @(posedge clk); #1; n++; end
                chk("b2b_sum", 64'(sum), 64'(exp[W-1:0]));
                chk("b2b_cout", 64'(cout), 64'(exp[W]));
                @(posedge clk); #1;
            end
            chk("b2b_gap1", 64'(acc[1] - acc[0]), 64'(NB + 2));
            chk("b2b_gap2", 64'(acc[2] - acc[1]), 64'(NB + 2));
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset after two RUN cycles; the aborted request must never produce a result.
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", {62'(0), in_ready, out_valid}, 64'b10);
        chk("abort_sum", {31'(0), cout, sum}, 64'(0));
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < NB + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        chk("abort_no_result", 64'(bad), 64'(0));
        out_ready = 1'b0;

`ifdef CLA8_SEQ_ADDER_SUB_EN
        txn("sub_5m7", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 0, t1);
        txn("sub_7m5", 32'h00000007, 32'h00000005, 1'b1, 1'b1, 1, t1);
`endif

        for (int k = 0; k < 12; k++) begin
            ra = $urandom; rb = $urandom;
            if (k == 0) rb = ~ra;
`ifdef CLA8_SEQ_ADDER_SUB_EN
            txn("rand", ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3), t2);
`else
            txn("rand", ra, rb, 1'($urandom), 1'b0, $urandom_range(0, 3), t2);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla8_seq_adder.md
# cla8_seq_adder

Multi-cycle wide adder controller that sequences a single internal `cla8` 8-bit carry-lookahead adder over an N-byte operand, one byte per cycle, with the carry chained through a register. It sits between a requester that presents wide operands and the shared 8-bit CLA datapath. It trades latency for area in the complex-multiplier partial-product accumulation path. Valid/ready handshakes are used on both input and output.

## Interface
- `NBYTES`, default 4: operand width in bytes; the data width W = 8*NBYTES; legal values are 1..16.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset; one clock, sampled on rising edge of `clk`.
- `in_valid`  in  1  requester has operands on `a`, `b`, `cin`.
- `in_ready`  out  1  block can accept a request (high only in IDLE).
- `a`  in  W  addend A.
- `b`  in  W  addend B.
- `cin`  in  1  carry into byte 0.
- `out_valid`  out  1  `sum` and `cout` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  W  registered result.
- `cout`  out  1  registered carry out of the top byte.

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `a`, `b` into operand registers, load carry register with `cin`, clear byte counter `cnt`=0, clear `sum` register, then go to RUN.
  - Operand inputs are ignored when no handshake occurs.
- RUN:
  - `in_ready`=0, `out_valid`=0.
  - The `cla8` sees byte `cnt` of A, byte `cnt` of B, and the carry register.
  - At the clock edge: `sum[8*cnt+:8]` takes the cla8 sum, the carry register takes the cla8 carry-out, and `cnt` increments.
  - If `cnt`==NBYTES-1 at the edge: go to DONE, `cout` takes the cla8 carry-out, and `cnt` returns to 0.
- DONE:
  - `out_valid`=1; `sum` and `cout` are held stable.
  - On `out_ready`=1: go to IDLE.
  - A new request cannot be accepted in the same cycle as `out_ready`, because `in_ready` is only high in IDLE.
- Arithmetic: `{cout,sum}` = A + B + cin, modulo 2^(W+1). No saturation and no signed interpretation.
- `cnt` is ceil(log2(NBYTES)) bits wide, minimum 1. It never exceeds NBYTES-1.
- Reset mid-operation (RUN or DONE) aborts the operation immediately:
  - State goes to IDLE.
  - `sum`, `cout`, `cnt` and the carry register are cleared.
  - Any partial result is discarded.
- Output reset values: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0.

## Timing
- If the accept handshake happens at edge E0, then RUN occupies the cycles ending at edges E1..E_NBYTES.
- `out_valid` rises immediately after edge E_NBYTES, so latency is NBYTES cycles from acceptance to a valid result.
- Minimum initiation interval is NBYTES+2 cycles, when `out_ready` is held at 1: NBYTES RUN cycles, 1 DONE cycle, 1 IDLE cycle.
- `out_ready` low stalls the block in DONE indefinitely with outputs frozen.
- `in_valid` and operands may change freely while `in_ready`=0.
- The combinational path from `cla8` to the registers is one 8-bit CLA plus a byte-select mux per cycle. No combinational path runs from inputs to outputs.
- NBYTES=1: a single RUN cycle, so `out_valid` appears one cycle after acceptance.

## Configuration
- Macro: `CLA8_SEQ_ADDER_SUB_EN`.
- Defined:
  - Adds input port `sub` (1 bit), latched at acceptance.
  - When `sub`=1, the operand B register loads ~`b` and the carry register loads 1, ignoring `cin`. The result is A − B, with `cout`=1 meaning no borrow.
  - When `sub`=0, behaviour is identical to the undefined case.
- Undefined: the `sub` port does not exist and the block only adds.

## Test plan
- **Reset values:** assert `rst` for 2 cycles, then release. Expect `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0.
- **Full carry ripple:** with NBYTES=4, send A=0xFFFFFFFF, B=0x00000001, cin=0. Expect `out_valid` exactly 4 cycles after acceptance with `sum`=0x00000000 and `cout`=1.
- **Carry-in only:** send A=0x12345678, B=0x11111111, cin=1. Expect `sum`=0x2345678A, `cout`=0. Hold `out_ready`=0 for 5 cycles and check outputs stay stable; then pulse `out_ready` and check IDLE is reached the next cycle.
- **Back-to-back requests:** keep `in_valid` high with `out_ready`=1 for 3 requests. Expect accepts spaced exactly 6 cycles apart and all results correct.
- **Reset mid-RUN:** assert `rst` at the edge after 2 RUN cycles. Expect IDLE with `out_valid`=0 and `sum`=0, and no result ever emitted for the aborted request.
- **Subtract (`CLA8_SEQ_ADDER_SUB_EN` defined):** send A=0x00000005, B=0x00000007, `sub`=1. Expect `sum`=0xFFFFFFFE and `cout`=0.
